spi_slave_ctrl: RTL and testbench
=================================

Name: spi_slave_ctrl

Overview:
Serial front end that drives the single-port RAM command interface from an SPI bus. It deserialises 10-bit command frames from MOSI and presents each one as a parallel word with a one-cycle rx_valid strobe. For read-data commands it waits for the RAM's tx_valid, then serialises the returned byte on MISO. The SPI bit clock is the system clock clk; the block is the initiator side of the RAM's din/rx_valid/dout/tx_valid handshake.

Parameters:
FRAME_W, 10, command frame width: 2 opcode bits plus 8 payload bits
DATA_W, 8, read-back data width shifted out on MISO

Ports:
clk  input  1  system clock, also the SPI bit clock; all sampling on the rising edge
rst_n  input  1  asynchronous active-low reset
ss_n  input  1  slave select, active low; high aborts or ends a transaction
mosi  input  1  serial command input, MSB first
miso  output  1  serial read data output, MSB first
rx_data  output  FRAME_W  assembled frame to RAM; [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload
rx_valid  output  1  one-cycle strobe: rx_data is a complete frame
tx_data  input  DATA_W  read data from RAM
tx_valid  input  1  RAM read data valid; treated as a level, may stay high

Behaviour:
- Reset (async, rst_n=0): state=IDLE; miso=0, rx_data=0, rx_valid=0, rd_addr_seen=0, bit counter=0, shift registers=0.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: miso=0. The edge that samples ss_n=0 moves to CHK_CMD (edge E0). No MOSI bit is taken at E0.
- CHK_CMD (E1): samples mosi into frame bit 9.
  - bit=0 -> WRITE.
  - bit=1 and rd_addr_seen=0 -> READ_ADD.
  - bit=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: edges E2..E10 sample frame bits 8..0, MSB first, using a 4-bit counter.
- After E10: rx_data is updated with the full frame, and rx_valid=1 for exactly the cycle between E10 and E11. rx_valid is a registered pulse.
- READ_ADD: rd_addr_seen is set at E10. READ_DATA: rd_addr_seen is cleared at E10. rd_addr_seen changes only on a completed frame.
- WRITE, READ_ADD: MOSI bits after the 10th are ignored. The block stays in state until ss_n=1.
- READ_DATA wait phase: tx_valid is sampled only from E12 onward, so a stale high level at E11 is ignored.
  - At the first such edge with tx_valid=1, tx_data is captured.
  - miso drives bit 7 from that edge, then bits 6..0 on the next 7 edges.
  - miso returns to 0 after bit 0.
  - Exactly one byte is sent per frame. Later tx_valid is ignored.
- ss_n=1 sampled in any non-IDLE state -> IDLE on that edge.
  - A partial frame is discarded: no rx_valid, rx_data is unchanged, rd_addr_seen is unchanged.
  - A MISO shift in progress is aborted and miso=0.
- rx_valid is never asserted in IDLE or CHK_CMD.
- tx_valid outside the READ_DATA wait phase has no effect.
- Opcode bit 8 is passed through unchecked. A frame 0b11 sent while rd_addr_seen=0 is routed to READ_ADD; the RAM decodes the opcode itself.
- Back-to-back frames require ss_n to go high for at least one cycle between them.

Decomposition:
- Shared package spi_ram_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11
  - state encoding constants
  - FRAME_W and DATA_W defaults
- One sub-module is natural: spi_shift_reg, a generic parameterised shift register with load/shift enables. It is instantiated once as the serial-in frame register and once as the parallel-in serial-out MISO register.
- The FSM and counter stay in spi_slave_ctrl.

Test Plan:
- Write address: ss_n low, mosi=00_1010_0101 -> rx_data=10'h0A5, one rx_valid pulse after the 10th bit; miso stays 0; rd_addr_seen=0.
- Write data: frame 01_0011_1100 -> rx_data=10'h13C, single rx_valid pulse. Sending 3 extra mosi bits before ss_n rises -> no second pulse.
- Read address then read data: frame 10_0000_0111 sets rd_addr_seen. Next transaction: frame 11_0000_0000, then tx_valid=1 with tx_data=8'hC3 one cycle after rx_valid -> miso serial 1,1,0,0,0,0,1,1 on consecutive edges, then 0; rd_addr_seen cleared.
- Stale tx_valid: hold tx_valid=1 with tx_data=8'h55 throughout, change tx_data to 8'hAA at E11 -> miso shifts 8'hAA, not 8'h55.
- Abort: raise ss_n after 6 bits of a frame -> state IDLE next edge, no rx_valid, rx_data unchanged. A following full 00_1111_0000 frame -> rx_data=10'h0F0.
- Async reset mid-MISO shift: rst_n=0 between edges -> miso, rx_valid and rd_addr_seen go to 0 immediately, without waiting for an edge; after release the FSM is in IDLE.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-to-RAM command front end: frame/data widths,
// RAM opcodes and the controller state encoding.
package spi_ram_pkg;

  localparam int DEFAULT_FRAME_W = 10;
  localparam int DEFAULT_DATA_W  = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } state_t;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// RAM-side command handshake: frames go out on rx_data/rx_valid and read data
// comes back on tx_data/tx_valid.
interface spi_slave_ctrl_if
  import spi_ram_pkg::*;
#(
  parameter int FRAME_W = DEFAULT_FRAME_W,
  parameter int DATA_W  = DEFAULT_DATA_W
);

  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_shift_reg.sv
// Generic left-shifting register with parallel load; load has priority over
// shift. Serves as both the serial-in frame register and the MISO register.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         shift_in,
  output logic [W-1:0] q
);

  logic [W-1:0] shifted;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == 0) begin : g_lsb
        assign shifted[gi] = shift_in;
      end else begin : g_upper
        assign shifted[gi] = q[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift) begin
      q <= shifted;
    end
  end

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave that turns 10-bit MOSI command frames into RAM commands and
// returns one read byte on MISO after each read-data frame.
module spi_slave_ctrl
  import spi_ram_pkg::*;
#(
  parameter int FRAME_W = DEFAULT_FRAME_W,
  parameter int DATA_W  = DEFAULT_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  spi_slave_ctrl_if.master ram
);

  // Counter phases inside a frame state: 0..CNT_LAST receiving payload bits,
  // CNT_DONE frame complete, CNT_WAIT waiting for tx_valid, CNT_SENT byte taken.
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 2);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_WAIT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SENT = CNT_W'(FRAME_W + 1);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               rd_addr_seen_reg;
  logic               miso_reg;
  logic               rx_valid_reg;
  logic [FRAME_W-1:0] rx_data_reg;

  logic [FRAME_W-2:0] frame_q;
  logic [DATA_W-1:0]  piso_q;
  logic [DATA_W-1:0]  piso_load_data;
  logic               in_frame;
  logic               frame_load;
  logic               frame_shift;
  logic               tx_capture;
  logic               tx_shift;
  logic               piso_load;

  assign in_frame    = !ss_n && (state_reg inside {ST_WRITE, ST_READ_ADD, ST_READ_DATA});
  assign frame_load  = (state_reg == ST_IDLE);
  assign frame_shift = (!ss_n && state_reg == ST_CHK_CMD) || (in_frame && cnt_reg < CNT_LAST);

  assign tx_capture  = in_frame && state_reg == ST_READ_DATA && cnt_reg == CNT_WAIT && ram.tx_valid;
  // A marker 1 trails the data bits; the byte is finished once only it is left.
  assign tx_shift    = in_frame && state_reg == ST_READ_DATA && cnt_reg == CNT_SENT
                       && (|piso_q[DATA_W-2:0]);
  assign piso_load      = frame_load || tx_capture;
  assign piso_load_data = tx_capture ? {ram.tx_data[DATA_W-2:0], 1'b1} : '0;

  spi_shift_reg #(.W(FRAME_W - 1)) u_frame_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (frame_load),
    .load_data ('0),
    .shift     (frame_shift),
    .shift_in  (mosi),
    .q         (frame_q)
  );

  spi_shift_reg #(.W(DATA_W)) u_miso_sr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (piso_load),
    .load_data (piso_load_data),
    .shift     (tx_shift),
    .shift_in  (1'b0),
    .q         (piso_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      rd_addr_seen_reg <= 1'b0;
      miso_reg         <= 1'b0;
      rx_valid_reg     <= 1'b0;
      rx_data_reg      <= '0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (state_reg != ST_IDLE && ss_n) begin
        // Deselect drops any partial frame or byte in flight.
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
        miso_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            miso_reg <= 1'b0;
            cnt_reg  <= '0;
            if (!ss_n) begin
              state_reg <= ST_CHK_CMD;
            end
          end
          ST_CHK_CMD: begin
            cnt_reg <= '0;
            if (!mosi) begin
              state_reg <= ST_WRITE;
            end else if (!rd_addr_seen_reg) begin
              state_reg <= ST_READ_ADD;
            end else begin
              state_reg <= ST_READ_DATA;
            end
          end
          ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            if (cnt_reg < CNT_DONE) begin
              cnt_reg  <= cnt_reg + CNT_W'(1);
              miso_reg <= 1'b0;
              if (cnt_reg == CNT_LAST) begin
                rx_data_reg  <= {frame_q, mosi};
                rx_valid_reg <= 1'b1;
                if (state_reg == ST_READ_ADD) begin
                  rd_addr_seen_reg <= 1'b1;
                end else if (state_reg == ST_READ_DATA) begin
                  rd_addr_seen_reg <= 1'b0;
                end
              end
            end else if (state_reg == ST_READ_DATA) begin
              // The edge right after completion is skipped so a stale tx_valid is ignored.
              if (cnt_reg == CNT_DONE) begin
                cnt_reg  <= CNT_WAIT;
                miso_reg <= 1'b0;
              end else if (tx_capture) begin
                cnt_reg  <= CNT_SENT;
                miso_reg <= ram.tx_data[DATA_W-1];
              end else if (tx_shift) begin
                miso_reg <= piso_q[DATA_W-1];
              end else begin
                miso_reg <= 1'b0;
              end
            end else begin
              miso_reg <= 1'b0;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            miso_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign miso         = miso_reg;
  assign ram.rx_data  = rx_data_reg;
  assign ram.rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed and random transactions against a transaction-level model of the
// SPI command front end; outputs are sampled on the falling clock edge.
module tb_spi_slave_ctrl;
  import spi_ram_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic ss_n;
  logic mosi;
  logic miso;

  spi_slave_ctrl_if #(.FRAME_W(10), .DATA_W(8)) ram_if ();

  spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ss_n  (ss_n),
    .mosi  (mosi),
    .miso  (miso),
    .ram   (ram_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model state: last completed frame and whether a read address is pending.
  logic       m_seen = 1'b0;
  logic [9:0] m_rx   = 10'h000;

  // Per-edge tx stimulus, indexed by edge number within a transaction (E0 = 0).
  logic       tv [0:63];
  logic [7:0] td [0:63];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic fill_tx(input bit noisy);
    for (int k = 0; k < 64; k++) begin
      tv[k] = noisy ? 1'($urandom_range(1, 0)) : 1'b0;
      td[k] = 8'($urandom);
    end
  endtask

  // Drives one select window of len edges with ss_n low, then one edge with ss_n
  // high. rst_k >= 0 pulses the async reset between edges rst_k and rst_k+1.
  task automatic run_txn(input logic [9:0] frame, input int len, input int rst_k);
    logic       complete;
    logic       is_rd;
    logic       exp_miso;
    logic [7:0] cap_data;
    logic [9:0] exp_rx;
    int         cap;
    complete = (len >= 11);
    is_rd    = frame[9] & m_seen;
    cap      = -1;
    cap_data = 8'h00;
    if (complete && is_rd) begin
      for (int k = 12; k < len; k++) begin
        if (tv[k] && cap < 0) begin
          cap      = k;
          cap_data = td[k];
        end
      end
    end
    for (int k = 0; k <= len; k++) begin
      ss_n = (k == len);
      if (k >= 1 && k <= 10) mosi = frame[10-k];
      else mosi = 1'($urandom_range(1, 0));
      ram_if.tx_valid = tv[k];
      ram_if.tx_data  = td[k];
      @(negedge clk);
      exp_miso = 1'b0;
      if (k < len && cap >= 0 && k >= cap && k <= cap + 7) exp_miso = cap_data[7-(k-cap)];
      exp_rx = (complete && k >= 10) ? frame : m_rx;
      chk("miso", k, 32'(miso), 32'(exp_miso));
      chk("rx_valid", k, 32'(ram_if.rx_valid), 32'(complete && k == 10));
      chk("rx_data", k, 32'(ram_if.rx_data), 32'(exp_rx));
      if (k == rst_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_miso", k, 32'(miso), 32'(1'b0));
        chk("rst_rx_valid", k, 32'(ram_if.rx_valid), 32'(1'b0));
        chk("rst_rx_data", k, 32'(ram_if.rx_data), 32'(10'h000));
        chk("rst_seen", k, 32'(dut.rd_addr_seen_reg), 32'(1'b0));
        m_seen = 1'b0;
        m_rx   = 10'h000;
        @(negedge clk);
        chk("rst_hold_miso", k, 32'(miso), 32'(1'b0));
        ss_n  = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", k, 32'(dut.state_reg), 32'(ST_IDLE));
        ram_if.tx_valid = 1'b0;
        return;
      end
    end
    if (complete) begin
      if (frame[9]) m_seen = ~is_rd;
      m_rx = frame;
    end
    chk("state_idle", len, 32'(dut.state_reg), 32'(ST_IDLE));
    chk("rd_addr_seen", len, 32'(dut.rd_addr_seen_reg), 32'(m_seen));
    ram_if.tx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ss_n  = 1'b1;
    mosi  = 1'b0;
    ram_if.tx_valid = 1'b0;
    ram_if.tx_data  = 8'h00;
    @(negedge clk);
    chk("reset_miso", 0, 32'(miso), 32'(1'b0));
    chk("reset_rx_valid", 0, 32'(ram_if.rx_valid), 32'(1'b0));
    chk("reset_rx_data", 0, 32'(ram_if.rx_data), 32'(10'h000));
    chk("reset_state", 0, 32'(dut.state_reg), 32'(ST_IDLE));
    chk("reset_seen", 0, 32'(dut.rd_addr_seen_reg), 32'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);

    // Write address, with tx_valid noise that must have no effect.
    fill_tx(1'b1);
    run_txn(10'h0A5, 11, -1);

    // Write data followed by three ignored extra bits.
    fill_tx(1'b1);
    run_txn(10'h13C, 14, -1);

    // Read address, then read data returning 8'hC3.
    fill_tx(1'b0);
    run_txn(10'h207, 11, -1);
    fill_tx(1'b0);
    for (int k = 0; k < 64; k++) begin
      td[k] = 8'hC3;
      tv[k] = (k >= 11);
    end
    run_txn({OP_RD_DATA, 8'h00}, 22, -1);

    // Stale tx_valid: 8'h55 up to and including E11, 8'hAA afterwards.
    fill_tx(1'b0);
    run_txn({OP_RD_ADDR, 8'($urandom)}, 12, -1);
    for (int k = 0; k < 64; k++) begin
      tv[k] = 1'b1;
      td[k] = (k <= 11) ? 8'h55 : 8'hAA;
    end
    run_txn({OP_RD_DATA, 8'h00}, 23, -1);

    // Abort after six bits, then a full write-address frame.
    fill_tx(1'b1);
    run_txn(10'($urandom), 7, -1);
    fill_tx(1'b1);
    run_txn(10'h0F0, 11, -1);

    // Random frames, lengths and tx_valid patterns, biased towards reads.
    for (int n = 0; n < 30; n++) begin
      logic [9:0] f;
      f = 10'($urandom);
      if ($urandom_range(3, 0) != 0) f[9] = 1'b1;
      fill_tx(1'b1);
      run_txn(f, int'($urandom_range(26, 1)), -1);
    end

    // Async reset while a read byte is being shifted out.
    fill_tx(1'b0);
    if (m_seen) run_txn({OP_RD_DATA, 8'h00}, 11, -1);
    run_txn({OP_RD_ADDR, 8'h12}, 11, -1);
    for (int k = 0; k < 64; k++) begin
      tv[k] = (k >= 12);
      td[k] = 8'hFF;
    end
    run_txn({OP_RD_DATA, 8'h00}, 30, 14);

    // Normal operation after the reset.
    fill_tx(1'b1);
    run_txn(10'h05A, 11, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
